// File: rtl/onchip_mem_arbiter_if.sv
// onchip_mem_arbiter_if: two requester ports plus the shared RAM port of the arbiter
interface onchip_mem_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   m0_address, m1_address, mem_address;
   logic [DATA_W/8-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
   logic                m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0]   m0_writedata, m1_writedata, mem_writedata;
   logic                m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0]   m0_readdata, m1_readdata, mem_readdata;
   logic                m0_readdatavalid, m1_readdatavalid;
   logic                mem_chipselect, mem_write, mem_clken;
   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      output mem_readdata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
   );
   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      input  mem_readdata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
   );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: grants one of two requesters per cycle onto a 1-cycle-latency RAM
module onchip_mem_arbiter #(
   parameter int ADDR_W       = 15,
   parameter int DATA_W       = 32,
   parameter int PRIO_MODE    = 0,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   onchip_mem_arbiter_if.slave  bus
);
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
   logic                a0, a1, g0, g1, w, at_limit, last_grant, tag_v, tag_id;
   logic [7:0]          starve_cnt;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W/8-1:0] be;
   logic [DATA_W-1:0]   wdata;
   always_comb begin
      a0       = bus.m0_read | bus.m0_write;
      a1       = bus.m1_read | bus.m1_write;
      at_limit = starve_cnt == LIMIT;
      g1       = reset_n & a1 & (~a0 | (PRIO_MODE == 0 ? ~last_grant : at_limit));
      g0       = reset_n & a0 & ~g1;
      w        = g1 ? bus.m1_write : g0 & bus.m0_write;
      addr     = g1 ? bus.m1_address : bus.m0_address;
      be       = g1 ? bus.m1_byteenable : bus.m0_byteenable;
      wdata    = g1 ? bus.m1_writedata : bus.m0_writedata;
   end
   assign bus.m0_waitrequest   = ~reset_n | (a0 & ~g0);
   assign bus.m1_waitrequest   = ~reset_n | (a1 & ~g1);
   assign bus.mem_address      = addr;
   assign bus.mem_byteenable   = be;
   assign bus.mem_writedata    = wdata;
   assign bus.mem_chipselect   = g0 | g1;
   assign bus.mem_write        = w;
   assign bus.mem_clken        = 1'b1;
   assign bus.m0_readdata      = bus.mem_readdata;
   assign bus.m1_readdata      = bus.mem_readdata;
   assign bus.m0_readdatavalid = tag_v & ~tag_id;
   assign bus.m1_readdatavalid = tag_v & tag_id;
   // the read tag clears asynchronously so a read caught by reset never returns
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         last_grant <= 1'b1;
         starve_cnt <= '0;
         tag_v      <= 1'b0;
         tag_id     <= 1'b0;
      end else begin
         if (g0 | g1) last_grant <= g1;
         starve_cnt <= a1 & ~g1 ? (at_limit ? starve_cnt : starve_cnt + 8'd1) : '0;
         tag_v      <= (g0 | g1) & ~w;
         tag_id     <= g1;
      end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: round-robin and fixed-priority arbiters driven in lockstep
// against a per-cycle reference model and a read-return scoreboard.
module tb_onchip_mem_arbiter;
   localparam int AW = 15;
   localparam int DW = 32;
   typedef struct { logic r, w; logic [AW-1:0] a; logic [3:0] b; logic [DW-1:0] d; } req_t;
   typedef struct { int id; logic [DW-1:0] data; } exp_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   logic [1:0]    rd, wr;
   logic [AW-1:0] ad [2];
   logic [3:0]    be [2];
   logic [DW-1:0] wd [2];
   logic [1:0]    wq [2];
   logic [1:0]    rdv [2];
   logic          cs [2], mw [2], ck [2];
   logic [AW-1:0] ma [2];
   logic [DW-1:0] rdat [2][2];
   int vectors = 0, miscompares = 0;
   int last_g [2], starve [2], gdut [2], vcnt [2][2];
   logic [DW-1:0] last_rd [2][2];
   logic [DW-1:0] mm [2][0:(1<<AW)-1];
   exp_t eq [2][$];
   for (genvar k = 0; k < 2; k++) begin : g
      onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
      logic [DW-1:0] ram [0:(1<<AW)-1];
      assign bus.m0_read = rd[0];
      assign bus.m0_write = wr[0];
      assign bus.m0_address = ad[0];
      assign bus.m0_byteenable = be[0];
      assign bus.m0_writedata = wd[0];
      assign bus.m1_read = rd[1];
      assign bus.m1_write = wr[1];
      assign bus.m1_address = ad[1];
      assign bus.m1_byteenable = be[1];
      assign bus.m1_writedata = wd[1];
      assign wq[k] = {bus.m1_waitrequest, bus.m0_waitrequest};
      assign rdv[k] = {bus.m1_readdatavalid, bus.m0_readdatavalid};
      assign rdat[k][0] = bus.m0_readdata;
      assign rdat[k][1] = bus.m1_readdata;
      assign cs[k] = bus.mem_chipselect;
      assign mw[k] = bus.mem_write;
      assign ma[k] = bus.mem_address;
      assign ck[k] = bus.mem_clken;
      initial for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
      always @(posedge clk) begin
         if (bus.mem_chipselect && bus.mem_write)
            for (int b = 0; b < 4; b++)
               if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
         bus.mem_readdata <= ram[bus.mem_address];
      end
      onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(k), .STARVE_LIMIT(k == 0 ? 8 : 3)) dut (
         .clk(clk), .reset_n(reset_n), .bus(bus.slave));
   end
   task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask
   function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [3:0] b);
      for (int i = 0; i < 4; i++) if (b[i]) o[8*i +: 8] = n[8*i +: 8];
      return o;
   endfunction
   function automatic int mgrant(input int k, input bit a0, input bit a1);
      if (!a0 && !a1) return -1;
      if (!(a0 && a1)) return a1 ? 1 : 0;
      if (k == 0) return last_g[0] == 0 ? 1 : 0;
      return starve[1] == 3 ? 1 : 0;
   endfunction
   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         last_g[k] = 1;
         starve[k] = 0;
         eq[k].delete();
      end
   endtask
   task automatic drive(input req_t x0, input req_t x1);
      rd = {x1.r, x0.r};
      wr = {x1.w, x0.w};
      ad[0] = x0.a; ad[1] = x1.a;
      be[0] = x0.b; be[1] = x1.b;
      wd[0] = x0.d; wd[1] = x1.d;
   endtask
   task automatic cyc(input req_t x0, input req_t x1);
      req_t x;
      bit a0, a1;
      int gm;
      @(negedge clk);
      drive(x0, x1);
      #2;
      a0 = x0.r | x0.w;
      a1 = x1.r | x1.w;
      for (int k = 0; k < 2; k++) begin
         gm = mgrant(k, a0, a1);
         gdut[k] = !cs[k] ? -1 : (a1 && !wq[k][1]) ? 1 : 0;
         chk("m0_waitrequest", k, wq[k][0], a0 && gm != 0);
         chk("m1_waitrequest", k, wq[k][1], a1 && gm != 1);
         chk("mem_chipselect", k, cs[k], gm >= 0);
         if (gm >= 0) begin
            x = gm == 1 ? x1 : x0;
            chk("mem_write", k, mw[k], x.w);
            chk("mem_address", k, ma[k], x.a);
            if (x.w) mm[k][x.a] = merge(mm[k][x.a], x.d, x.b);
            else eq[k].push_back('{gm, mm[k][x.a]});
            last_g[k] = gm;
         end else chk("mem_write idle", k, mw[k], 0);
         starve[k] = (a1 && gm != 1) ? (starve[k] + 1 > (k == 0 ? 8 : 3) ? starve[k] : starve[k] + 1) : 0;
      end
   endtask
   initial begin
      exp_t e;
      int n;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            n = eq[k].size();
            chk("readdatavalid", k, rdv[k], n != 0 ? 2'b01 << eq[k][0].id : 2'b00);
            if (n != 0) begin
               e = eq[k].pop_front();
               chk("readdata", k, rdat[k][e.id], e.data);
               last_rd[k][e.id] = rdat[k][e.id];
               vcnt[k][e.id]++;
            end
         end
      end
   end
   initial begin
      req_t idle, rr0, rr1;
      int pat1 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      int c0;
      idle = '{1'b0, 1'b0, '0, 4'h0, '0};
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < (1 << AW); i++) mm[k][i] = '0;
         vcnt[k] = '{0, 0};
      end
      model_reset();
      drive('{1'b1, 1'b0, 15'h1, 4'hF, '0}, '{1'b0, 1'b1, 15'h2, 4'hF, 32'h1});
      #12;
      for (int k = 0; k < 2; k++) begin
         chk("reset waitrequest", k, wq[k], 2'b11);
         chk("reset chipselect", k, cs[k], 0);
         chk("reset mem_write", k, mw[k], 0);
         chk("reset readdatavalid", k, rdv[k], 2'b00);
         chk("mem_clken", k, ck[k], 1);
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      rr0 = '{1'b1, 1'b0, 15'h1, 4'hF, '0};
      rr1 = '{1'b1, 1'b0, 15'h2, 4'hF, '0};
      for (int i = 0; i < 8; i++) begin
         cyc(rr0, rr1);
         chk("rr grant", 0, gdut[0], i % 2);
         chk("prio grant", 1, gdut[1], pat1[i]);
      end
      cyc('{1'b0, 1'b1, 15'h10, 4'hF, 32'hDEADBEEF}, idle);
      last_rd[0][1] = '0; last_rd[1][1] = '0;
      cyc(idle, '{1'b1, 1'b0, 15'h10, 4'hF, '0});
      cyc(idle, idle);
      for (int k = 0; k < 2; k++) chk("m1 read 0x10", k, last_rd[k][1], 32'hDEADBEEF);
      cyc('{1'b0, 1'b1, 15'h20, 4'hF, 32'hFFFFFFFF}, idle);
      cyc('{1'b0, 1'b1, 15'h20, 4'h5, 32'h11223344}, idle);
      cyc('{1'b1, 1'b0, 15'h20, 4'hF, '0}, idle);
      cyc(idle, idle);
      for (int k = 0; k < 2; k++) chk("byteenable merge", k, last_rd[k][0], 32'hFF22FF44);
      cyc('{1'b0, 1'b1, 15'h7FFF, 4'hF, 32'hCAFEF00D}, idle);
      c0 = vcnt[0][1];
      cyc(idle, '{1'b1, 1'b0, 15'h7FFF, 4'hF, '0});
      cyc(idle, '{1'b1, 1'b0, 15'h0000, 4'hF, '0});
      cyc(idle, idle);
      chk("m1 back-to-back count", 0, vcnt[0][1] - c0, 2);
      chk("m1 read 0x0000", 0, last_rd[0][1], 32'h0);
      @(negedge clk);
      drive(idle, '{1'b1, 1'b0, 15'h10, 4'hF, '0});
      #2;
      for (int k = 0; k < 2; k++) chk("pre-reset grant", k, wq[k], 2'b00);
      #1 reset_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset waitrequest", k, wq[k], 2'b11);
         chk("reset chipselect", k, cs[k], 0);
      end
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      cyc(idle, idle);
      cyc(idle, idle);
      for (int i = 0; i < 500; i++) begin
         req_t x [2];
         for (int r = 0; r < 2; r++) begin
            int op;
            op = $urandom_range(0, 3);
            x[r].r = op == 1 || op == 3;
            x[r].w = op >= 2;
            x[r].a = $urandom_range(0, 9) == 0 ? 15'h7FFF : 15'($urandom_range(0, 7));
            x[r].b = 4'($urandom);
            x[r].d = $urandom;
         end
         cyc(x[0], x[1]);
      end
      cyc(idle, idle);
      cyc(idle, idle);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
